// File: rtl/hack_pkg.sv
// Shared widths and enums for the Hack memory blocks (RAM8 and the RAM64 built from it).
package hack_pkg;

    localparam int WORD_W      = 16;
    localparam int RAM8_DEPTH  = 8;
    localparam int RAM8_ADDR_W = 3;

    typedef logic [WORD_W-1:0]      word_t;
    typedef logic [RAM8_ADDR_W-1:0] ram8_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/dmux8way.sv
// One-bit eight-way demultiplexer: routes in to the output chosen by sel, others stay 0.
import hack_pkg::*;

module dmux8way (
    input  logic                   in,
    input  logic [RAM8_ADDR_W-1:0] sel,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    output logic                   d,
    output logic                   e,
    output logic                   f,
    output logic                   g,
    output logic                   h
);

    always_comb begin
        a = in && (sel == 3'd0);
        b = in && (sel == 3'd1);
        c = in && (sel == 3'd2);
        d = in && (sel == 3'd3);
        e = in && (sel == 3'd4);
        f = in && (sel == 3'd5);
        g = in && (sel == 3'd6);
        h = in && (sel == 3'd7);
    end

endmodule

// File: rtl/mux8way16.sv
// Eight-input 16-bit multiplexer, Hack style: sel=0 picks a, sel=7 picks h.
import hack_pkg::*;

module mux8way16 (
    input  logic [WORD_W-1:0]      a,
    input  logic [WORD_W-1:0]      b,
    input  logic [WORD_W-1:0]      c,
    input  logic [WORD_W-1:0]      d,
    input  logic [WORD_W-1:0]      e,
    input  logic [WORD_W-1:0]      f,
    input  logic [WORD_W-1:0]      g,
    input  logic [WORD_W-1:0]      h,
    input  logic [RAM8_ADDR_W-1:0] sel,
    output logic [WORD_W-1:0]      out
);

    always_comb begin
        out = a;
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            3'd7:    out = h;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/ram8_16.sv
// Eight-word x 16-bit Hack RAM8 with a combinational read port and a
// valid/ready dump engine that streams word[0..7] from a holding register.
import hack_pkg::*;

module ram8_16 #(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = RAM8_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]       out,
    input  logic                   dump_start,
    output logic                   dump_busy,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [RAM8_ADDR_W-1:0] dump_addr,
    output logic [WIDTH-1:0]       dump_data,
    output logic                   dump_done
);

    logic [WIDTH-1:0] words_q [DEPTH];
    logic [WIDTH-1:0] words_d [DEPTH];
    logic [DEPTH-1:0] word_we;

    dump_state_e            state_q, state_d;
    logic [RAM8_ADDR_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [RAM8_ADDR_W-1:0] next_idx;
    logic [WIDTH-1:0]       capture_word;

    dmux8way u_we_decode (
        .in  (load),
        .sel (address),
        .a   (word_we[0]),
        .b   (word_we[1]),
        .c   (word_we[2]),
        .d   (word_we[3]),
        .e   (word_we[4]),
        .f   (word_we[5]),
        .g   (word_we[6]),
        .h   (word_we[7])
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            words_d[i] = word_we[i] ? in : words_q[i];
        end
    end

    mux8way16 u_read_mux (
        .a   (words_q[0]),
        .b   (words_q[1]),
        .c   (words_q[2]),
        .d   (words_q[3]),
        .e   (words_q[4]),
        .f   (words_q[5]),
        .g   (words_q[6]),
        .h   (words_q[7]),
        .sel (address),
        .out (out)
    );

    // The capture mux reads words_q, so a same-edge write is never seen by the held word.
    assign next_idx = (state_q == SEND) ? idx_q + 3'd1 : 3'd0;

    mux8way16 u_capture_mux (
        .a   (words_q[0]),
        .b   (words_q[1]),
        .c   (words_q[2]),
        .d   (words_q[3]),
        .e   (words_q[4]),
        .f   (words_q[5]),
        .g   (words_q[6]),
        .h   (words_q[7]),
        .sel (next_idx),
        .out (capture_word)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = SEND;
                    idx_d   = 3'd0;
                    data_d  = capture_word;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = capture_word;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                words_q[i] <= '0;
            end
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                words_q[i] <= words_d[i];
            end
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dump_valid = valid_q;
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;
    assign dump_addr  = idx_q;
    assign dump_data  = data_q;

endmodule

// File: tb/tb_ram8_16.sv
// Self-checking bench for ram8_16: direct read-port checks plus a scoreboard
// that the dump monitor drains on every valid&ready beat.
module tb_ram8_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;
    logic        dump_start;
    logic        dump_busy;
    logic        dump_valid;
    logic        dump_ready;
    logic [2:0]  dump_addr;
    logic [15:0] dump_data;
    logic        dump_done;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_count   = 0;
    int done_base;
    int edges;

    logic [18:0] exp_q [$];
    logic [18:0] beat_exp;

    logic [15:0] word_vals [8] = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000,
                                   16'h1234, 16'h4321, 16'h9876, 16'h6789};

    ram8_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (din),
        .load       (load),
        .address    (address),
        .out        (out),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted dump beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (dump_done) done_count++;
        if (rst_n && dump_valid && dump_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL dump_beat: got addr=%0d data=%h, expected no beat", dump_addr, dump_data);
            end else begin
                beat_exp = exp_q.pop_front();
                if ({dump_addr, dump_data} !== beat_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL dump_beat: got addr=%0d data=%h, expected addr=%0d data=%h",
                             dump_addr, dump_data, beat_exp[18:16], beat_exp[15:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [2:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        load    = ld;
        address = a;
        din     = d;
    endtask

    task automatic readCheck(input string name, input logic [2:0] a, input logic [15:0] e);
        applyStimulus(1'b0, a, 16'h0000);
        @(negedge clk);
        checkOutput($sformatf("%s[%0d]", name, a), out, e);
    endtask

    task automatic pulseStart();
        @(posedge clk);
        #1 dump_start = 1'b1;
        @(posedge clk);
        #1 dump_start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!dump_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!dump_done) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL dump_done_timeout: got no pulse in %0d cycles, expected one", limit);
        end
    endtask

    task automatic waitAddr(input logic [2:0] a);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (dump_valid && dump_addr == a) return;
        end
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL wait_addr: got addr=%0d valid=%0b, expected addr=%0d", dump_addr, dump_valid, a);
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 16'h0000;
        load       = 1'b0;
        address    = 3'd0;
        dump_start = 1'b0;
        dump_ready = 1'b1;

        // Reset then read
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {15'b0, dump_busy}, 16'h0000);
        checkOutput("reset_valid", {15'b0, dump_valid}, 16'h0000);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) readCheck("reset_read", 3'(i), 16'h0000);
        checkOutput("idle_busy", {15'b0, dump_busy}, 16'h0000);
        checkOutput("idle_valid", {15'b0, dump_valid}, 16'h0000);

        // Write a..h then read back
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), word_vals[i]);
        for (int i = 0; i < 8; i++) readCheck("wr_read", 3'(i), word_vals[i]);

        // Overwrite word 5: no bypass, so the old value shows until the edge
        applyStimulus(1'b1, 3'd5, 16'hBEEF);
        @(negedge clk);
        checkOutput("beef_before_edge", out, 16'h4321);
        applyStimulus(1'b0, 3'd5, 16'h0000);
        @(negedge clk);
        checkOutput("beef_after_edge", out, 16'hBEEF);
        word_vals[5] = 16'hBEEF;
        readCheck("beef_neighbour", 3'd4, 16'h1234);
        readCheck("beef_neighbour", 3'd6, 16'h9876);

        // Full-speed dump
        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), word_vals[i]});
        done_base = done_count;
        @(posedge clk);
        #1 dump_start = 1'b1;
        @(posedge clk);
        #1 dump_start = 1'b0;
        edges = 1;
        @(negedge clk);
        while (!dump_done && edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("done_latency", 16'(edges), 16'd9);
        @(negedge clk);
        checkOutput("post_dump_busy", {15'b0, dump_busy}, 16'h0000);
        checkOutput("post_dump_done", {15'b0, dump_done}, 16'h0000);
        checkOutput("dump1_done_count", 16'(done_count - done_base), 16'd1);
        checkOutput("dump1_sb_empty", 16'(exp_q.size()), 16'd0);

        // Backpressure at idx 2 with a concurrent write to word 2
        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), word_vals[i]});
        done_base = done_count;
        @(posedge clk);
        #1 dump_start = 1'b1;
        waitAddr(3'd2);
        dump_start = 1'b0;
        dump_ready = 1'b0;
        load       = 1'b1;
        address    = 3'd2;
        din        = 16'h0F0F;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_data_%0d", k), dump_data, 16'hFFFF);
            checkOutput($sformatf("stall_valid_%0d", k), {15'b0, dump_valid}, 16'h0001);
            @(posedge clk);
            #1 load = 1'b0;
        end
        dump_ready = 1'b1;

        // A start request mid-stream must be dropped
        waitAddr(3'd4);
        dump_start = 1'b1;
        @(posedge clk);
        #1 dump_start = 1'b0;
        waitDone(20);
        repeat (14) @(negedge clk);
        checkOutput("dump2_done_count", 16'(done_count - done_base), 16'd1);
        checkOutput("dump2_busy", {15'b0, dump_busy}, 16'h0000);
        checkOutput("dump2_sb_empty", 16'(exp_q.size()), 16'd0);
        word_vals[2] = 16'h0F0F;
        readCheck("bp_readback", 3'd2, 16'h0F0F);

        // Reset asserted at idx 6 aborts the dump
        for (int i = 0; i < 6; i++) exp_q.push_back({3'(i), word_vals[i]});
        done_base = done_count;
        pulseStart();
        waitAddr(3'd6);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", {15'b0, dump_valid}, 16'h0000);
        checkOutput("abort_busy", {15'b0, dump_busy}, 16'h0000);
        for (int i = 0; i < 8; i++) readCheck("abort_read", 3'(i), 16'h0000);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", 16'(done_count - done_base), 16'd0);
        checkOutput("abort_sb_empty", 16'(exp_q.size()), 16'd0);

        // Fresh dump after reset streams zeros
        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 16'h0000});
        done_base = done_count;
        pulseStart();
        waitDone(20);
        repeat (2) @(negedge clk);
        checkOutput("dump3_done_count", 16'(done_count - done_base), 16'd1);
        checkOutput("dump3_sb_empty", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
